// File: rtl/cpmath_io_port.sv
// CPMath I/O port: switch-entry FIFO with a blocking or non-blocking read handshake
// toward the control unit, plus NUM_OUT addressable output registers.
module cpmath_io_port #(
    parameter int DATA_W   = 16,
    parameter int WORD_W   = 32,
    parameter int DEPTH    = 4,
    parameter int NUM_OUT  = 2,
    parameter int BLOCKING = 1,
    localparam int SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         switch,
    input  logic                      enter,
    input  logic                      rd_req,
    output logic [WORD_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      stall,
    input  logic                      wr_en,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [WORD_W-1:0]         wr_data,
    output logic [NUM_OUT*WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clear_flags
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_enter_q;
    logic              r_pending;
    logic [WORD_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow, r_underflow;
    logic [WORD_W-1:0] r_out [NUM_OUT];

    logic w_push, w_pop, w_accept, w_empty, w_full;
    logic w_ovf_set, w_unf_set;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_push   = enter & ~r_enter_q;
    // Emptiness is taken from registered state, so a push into an empty FIFO
    // can only be popped on a later edge.
    assign w_pop    = (rd_req | r_pending) & ~w_empty;
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_unf_set = (BLOCKING == 0) & rd_req & w_empty;

    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem[r_wr_ptr] <= switch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_enter_q   <= 1'b1;
            r_pending   <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_enter_q <= enter;
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_accept && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_accept && w_pop)
                r_count <= r_count - CNT_W'(1);

            if (r_pending)
                r_pending <= ~w_pop;
            else
                r_pending <= (BLOCKING != 0) & rd_req & w_empty;

            if (w_pop) begin
                r_rd_data  <= WORD_W'(r_mem[r_rd_ptr]);
                r_rd_valid <= 1'b1;
            end else if (w_unf_set) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end

            if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (clear_flags)
                r_overflow <= 1'b0;
            if (w_unf_set)
                r_underflow <= 1'b1;
            else if (clear_flags)
                r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_out <= '{default: '0};
        else if (wr_en && (32'(wr_sel) < NUM_OUT))
            r_out[wr_sel] <= wr_data;
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++)
            out_data[k*WORD_W +: WORD_W] = r_out[k];
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign stall     = r_pending;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_cpmath_io_port.sv
// Directed bench for cpmath_io_port: a blocking instance (NUM_OUT=2) and a
// non-blocking instance (NUM_OUT=3, so an out-of-range wr_sel is expressible).
module tb_cpmath_io_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] switch;
    logic        enter, rd_req, wr_en, clear_flags;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid, stall, full, empty, overflow, underflow;
    logic [63:0] out_data;
    logic [2:0]  count;

    logic        nb_enter, nb_rd_req, nb_wr_en, nb_clear;
    logic [1:0]  nb_wr_sel;
    logic [31:0] nb_rd_data;
    logic        nb_rd_valid, nb_stall, nb_full, nb_empty, nb_overflow, nb_underflow;
    logic [95:0] nb_out_data;
    logic [2:0]  nb_count;
    logic        nb_stall_seen;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    cpmath_io_port #(.DATA_W(16), .WORD_W(32), .DEPTH(4), .NUM_OUT(2), .BLOCKING(1)) u_dut (
        .clk(clk), .reset(reset), .switch(switch), .enter(enter), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .out_data(out_data), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
        .clear_flags(clear_flags)
    );

    cpmath_io_port #(.DATA_W(16), .WORD_W(32), .DEPTH(4), .NUM_OUT(3), .BLOCKING(0)) u_nb (
        .clk(clk), .reset(reset), .switch(switch), .enter(nb_enter), .rd_req(nb_rd_req),
        .rd_data(nb_rd_data), .rd_valid(nb_rd_valid), .stall(nb_stall), .wr_en(nb_wr_en),
        .wr_sel(nb_wr_sel), .wr_data(wr_data), .out_data(nb_out_data), .count(nb_count),
        .full(nb_full), .empty(nb_empty), .overflow(nb_overflow), .underflow(nb_underflow),
        .clear_flags(nb_clear)
    );

    always @(posedge clk)
        if (nb_stall === 1'b1) nb_stall_seen <= 1'b1;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        switch = v;
        enter  = 1'b1;
        tick();
        enter  = 1'b0;
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [31:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk({tag, "_valid"}, 96'(rd_valid), 96'(1));
        chk({tag, "_data"}, 96'(rd_data), 96'(exp));
        tick();
        chk({tag, "_pulse"}, 96'(rd_valid), 96'(0));
    endtask

    initial begin
        reset = 1'b1; switch = '0; enter = 1'b0; rd_req = 1'b0; wr_en = 1'b0;
        wr_sel = 1'b0; wr_data = '0; clear_flags = 1'b0;
        nb_enter = 1'b0; nb_rd_req = 1'b0; nb_wr_en = 1'b0; nb_wr_sel = '0; nb_clear = 1'b0;
        nb_stall_seen = 1'b0;
        #1;
        chk("rst_count", 96'(count), 96'(0));
        chk("rst_empty", 96'(empty), 96'(1));
        chk("rst_valid", 96'(rd_valid), 96'(0));
        chk("rst_stall", 96'(stall), 96'(0));
        chk("rst_out", 96'(out_data), 96'(0));
        tick(); tick();
        reset = 1'b0;
        tick();

        // Basic push/read ordering
        push(16'h0005);
        push(16'h00A3);
        chk("t1_count2", 96'(count), 96'(2));
        read_expect("t1_rd0", 32'h0000_0005);
        read_expect("t1_rd1", 32'h0000_00A3);
        chk("t1_count0", 96'(count), 96'(0));
        chk("t1_empty", 96'(empty), 96'(1));

        // Blocking read on empty
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t2_stall_on", 96'(stall), 96'(1));
        chk("t2_no_valid", 96'(rd_valid), 96'(0));
        tick(); tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t2_stall_hold", 96'(stall), 96'(1));
        switch = 16'h1234; enter = 1'b1;
        tick();
        enter = 1'b0;
        chk("t2_pushed_cnt", 96'(count), 96'(1));
        chk("t2_stall_pre", 96'(stall), 96'(1));
        chk("t2_valid_pre", 96'(rd_valid), 96'(0));
        tick();
        chk("t2_valid", 96'(rd_valid), 96'(1));
        chk("t2_data", 96'(rd_data), 96'(32'h0000_1234));
        chk("t2_stall_off", 96'(stall), 96'(0));
        tick();
        chk("t2_one_pop", 96'(rd_valid), 96'(0));
        chk("t2_count0", 96'(count), 96'(0));

        // Fill, overflow, drain, clear
        push(16'h1); push(16'h2); push(16'h3);
        chk("t3_notfull", 96'(full), 96'(0));
        push(16'h4);
        chk("t3_full", 96'(full), 96'(1));
        chk("t3_no_ovf", 96'(overflow), 96'(0));
        push(16'h5);
        chk("t3_ovf", 96'(overflow), 96'(1));
        chk("t3_count4", 96'(count), 96'(4));
        read_expect("t3_rd1", 32'h1);
        read_expect("t3_rd2", 32'h2);
        read_expect("t3_rd3", 32'h3);
        read_expect("t3_rd4", 32'h4);
        chk("t3_ovf_sticky", 96'(overflow), 96'(1));
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t3_ovf_clr", 96'(overflow), 96'(0));

        // Simultaneous push and pop on a full FIFO
        push(16'h1); push(16'h2); push(16'h3); push(16'h4);
        switch = 16'h7; enter = 1'b1; rd_req = 1'b1;
        tick();
        enter = 1'b0; rd_req = 1'b0;
        chk("t4_rd", 96'(rd_data), 96'(32'h1));
        chk("t4_count", 96'(count), 96'(4));
        chk("t4_no_ovf", 96'(overflow), 96'(0));
        tick();
        read_expect("t4_rd2", 32'h2);
        read_expect("t4_rd3", 32'h3);
        read_expect("t4_rd4", 32'h4);
        read_expect("t4_rd7", 32'h7);
        chk("t4_empty", 96'(empty), 96'(1));

        // Non-blocking read on empty
        nb_rd_req = 1'b1;
        tick();
        nb_rd_req = 1'b0;
        chk("t5_valid", 96'(nb_rd_valid), 96'(1));
        chk("t5_data", 96'(nb_rd_data), 96'(0));
        chk("t5_unf", 96'(nb_underflow), 96'(1));
        tick();
        chk("t5_pulse", 96'(nb_rd_valid), 96'(0));
        nb_rd_req = 1'b1; nb_clear = 1'b1;
        tick();
        nb_rd_req = 1'b0; nb_clear = 1'b0;
        chk("t5_set_wins", 96'(nb_underflow), 96'(1));
        nb_clear = 1'b1;
        tick();
        nb_clear = 1'b0;
        chk("t5_unf_clr", 96'(nb_underflow), 96'(0));
        chk("t5_no_stall", 96'(nb_stall_seen), 96'(0));

        // Output registers
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h1111_1111;
        tick();
        wr_sel = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        chk("t6_out", 96'(out_data), 96'(64'hDEAD_BEEF_1111_1111));
        nb_wr_en = 1'b1; nb_wr_sel = 2'd2; wr_data = 32'hCAFE_0002;
        tick();
        nb_wr_sel = 2'd3; wr_data = 32'h0BAD_0BAD;
        tick();
        nb_wr_en = 1'b0;
        chk("t6_nb_oob", 96'(nb_out_data), {32'hCAFE_0002, 64'h0});

        // Reset during a pending read, enter held high across release
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t6_stall", 96'(stall), 96'(1));
        enter = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_stall", 96'(stall), 96'(0));
        chk("t6_rst_out", 96'(out_data), 96'(0));
        chk("t6_rst_cnt", 96'(count), 96'(0));
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("t6_no_push", 96'(count), 96'(0));
        chk("t6_no_valid", 96'(rd_valid), 96'(0));
        chk("t6_no_stall", 96'(stall), 96'(0));
        enter = 1'b0;
        tick();
        chk("t6_still_empty", 96'(empty), 96'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpmath_io_port.md
Name: cpmath_io_port

Overview:
Parametrised input/output port for the CPMath multi-cycle core. It replaces the single-word switch buffer and the display register with three parts:
- a DEPTH-entry FIFO fed by the debounced enter button,
- a blocking/non-blocking read handshake toward the control unit,
- NUM_OUT independently addressable output registers feeding the BCD/display path.

Parameters:
DATA_W, 16, switch input width
WORD_W, 32, core word width; read data is zero-extended DATA_W -> WORD_W
DEPTH, 4, FIFO entries; power of two, >= 2
NUM_OUT, 2, number of output registers
BLOCKING, 1, 1: read on empty stalls until data arrives; 0: read on empty returns 0 and sets underflow

Ports:
clk  in  1  core clock (divided clock)
reset  in  1  asynchronous, active-high
switch  in  DATA_W  switch value
enter  in  1  debounced enter level
rd_req  in  1  one-cycle read request from control unit (IN instruction)
rd_data  out  WORD_W  popped word, zero-extended
rd_valid  out  1  one-cycle pulse, rd_data valid
stall  out  1  read pending, core must hold state
wr_en  in  1  output write strobe (OUT instruction)
wr_sel  in  $clog2(NUM_OUT) max 1  output channel index
wr_data  in  WORD_W  value to latch
out_data  out  NUM_OUT*WORD_W  channel k at bits [k*WORD_W +: WORD_W]
count  out  $clog2(DEPTH)+1  FIFO occupancy
full  out  1  count==DEPTH
empty  out  1  count==0
overflow  out  1  sticky: push dropped on full
underflow  out  1  sticky: non-blocking read on empty
clear_flags  in  1  synchronous clear of overflow/underflow

Behaviour:
Reset (async, immediate):
- count=0, pointers=0, rd_data=0, rd_valid=0, stall=0, pending=0, out_data=0, overflow=0, underflow=0.
- enter_q=1, so an enter level held high through reset release does not push.

Push:
- push = enter & ~enter_q (rising edge). enter_q <= enter every cycle.
- The switch value is written at the tail on the same edge.
- Push when full and no pop in the same cycle: data dropped, overflow<=1, count unchanged.

Pop:
- pop = (rd_req | pending) & ~empty, with empty evaluated before this cycle's push.
- On the pop edge: rd_data<={0,head}, rd_valid<=1 for exactly one cycle; otherwise rd_valid<=0 and rd_data holds.
- Latency: rd_req to rd_valid is 1 cycle when non-empty.

Simultaneous push and pop:
- Both take effect; count unchanged. This is also true when full: the pop frees the slot and the push is accepted with no overflow.
- No bypass when empty: a push into an empty FIFO is popped no earlier than the next edge.

Read on empty:
- BLOCKING=1: pending<=1; stall = pending (registered, asserted the cycle after rd_req). While pending and ~empty: pop, pending<=0, stall drops with rd_valid. rd_req while pending is ignored.
- BLOCKING=0: rd_data<=0, rd_valid<=1 next cycle, underflow<=1, no pending, stall stays 0.

Output registers:
- wr_en with wr_sel<NUM_OUT: that channel <= wr_data on the edge; others hold.
- wr_sel>=NUM_OUT: ignored.
- Output writes are independent of FIFO activity and of stall.

Flags and status:
- clear_flags clears overflow/underflow. A same-cycle set event wins over the clear.
- count/full/empty are registered-state derived, combinational from count.
- Pointers wrap modulo DEPTH.

Reset mid-operation: pending read, stall and FIFO contents are discarded; no rd_valid is produced after reset.

Test Plan:
1. Reset, then enter pulses with switch=0x0005, 0x00A3, then rd_req twice -> rd_data=0x00000005 then 0x000000A3, each rd_valid one cycle after its rd_req; count returns 0, empty=1.
2. BLOCKING=1, empty FIFO, rd_req at cycle 0 -> stall=1 from cycle 1. Push switch=0x1234 at cycle 5 -> pop at cycle 6 edge, rd_valid=1 and rd_data=0x00001234 in cycle 6, stall=0 in cycle 6. A second rd_req during stall has no effect.
3. DEPTH=4: five pushes (0x1..0x5) -> full=1 after the 4th, overflow=1 after the 5th. Four reads return 1,2,3,4. clear_flags -> overflow=0.
4. Full FIFO, push 0x7 and rd_req on the same edge -> count stays 4, overflow stays 0; subsequent reads return 2,3,4,7.
5. BLOCKING=0, empty, rd_req -> rd_valid=1, rd_data=0, underflow=1, stall never asserted.
6. wr_en wr_sel=1 wr_data=0xDEADBEEF -> out_data[63:32]=0xDEADBEEF, [31:0] unchanged. wr_sel out of range -> no change. Assert reset while stall=1 -> all outputs 0 immediately; enter held high across reset release causes no push.
